push_button_debouncer: RTL and testbench



---
 rtl/push_button_debouncer.sv | 120 ++++++++++++
 tb/tb_push_button_debouncer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/push_button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// clean level plus single-cycle rise/fall pulses and a saturating bounce counter.
module push_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int unsigned BOUNCE_W        = 8
) (
    input  logic                input_clock1_clk_1,
    input  logic                input_push_button3_rst_3,
    input  logic                input_push_button2_d_2,
    output logic                output_led1_d_level_3,
    output logic                output_led2_rise_4,
    output logic                output_led3_fall_5,
    output logic                output_led4_busy_6,
    output logic [BOUNCE_W-1:0] output_bounce_count_7
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                sync1_q, sync2_q;
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [BOUNCE_W-1:0] bounce_q, bounce_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        bounce_d = bounce_q;
        case (state_q)
            IDLE_LOW: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    if (bounce_q != '1) bounce_d = bounce_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (sync2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    if (bounce_q != '1) bounce_d = bounce_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset overrides everything, including a transition that would complete this edge.
    always_ff @(posedge input_clock1_clk_1) begin
        if (input_push_button3_rst_3) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= '0;
        end else begin
            sync1_q  <= input_push_button2_d_2;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            bounce_q <= bounce_d;
        end
    end

    assign output_led1_d_level_3 = level_q;
    assign output_led2_rise_4    = rise_q;
    assign output_led3_fall_5    = fall_q;
    assign output_led4_busy_6    = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    assign output_bounce_count_7 = bounce_q;

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with DEBOUNCE_CYCLES=4; a second
// instance with BOUNCE_W=2 shares the stimulus to exercise counter saturation.
module tb_push_button_debouncer;

    logic       clk;
    logic       rst;
    logic       raw;
    logic       level, rise, fall, busy;
    logic [7:0] bc;
    logic       level2, rise2, fall2, busy2;
    logic [1:0] bc2;

    int nCompared;
    int nMismatched;

    push_button_debouncer #(.DEBOUNCE_CYCLES(4), .BOUNCE_W(8)) dut (
        .input_clock1_clk_1      (clk),
        .input_push_button3_rst_3(rst),
        .input_push_button2_d_2  (raw),
        .output_led1_d_level_3   (level),
        .output_led2_rise_4      (rise),
        .output_led3_fall_5      (fall),
        .output_led4_busy_6      (busy),
        .output_bounce_count_7   (bc)
    );

    push_button_debouncer #(.DEBOUNCE_CYCLES(4), .BOUNCE_W(2)) dutSat (
        .input_clock1_clk_1      (clk),
        .input_push_button3_rst_3(rst),
        .input_push_button2_d_2  (raw),
        .output_led1_d_level_3   (level2),
        .output_led2_rise_4      (rise2),
        .output_led3_fall_5      (fall2),
        .output_led4_busy_6      (busy2),
        .output_bounce_count_7   (bc2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        raw = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = 1'b1;
        tick(); tick(); tick();
        nCompared++;
        if ({level, rise, fall, busy} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {level, rise, fall, busy});
        end
        nCompared++;
        if (bc !== 8'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_bc: got %0d want 0", bc);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        nCompared++;
        if ({level, rise} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_edge5: level/rise got %b want 00", {level, rise});
        end
        tick();
        nCompared++;
        if ({level, rise} !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL reset_edge6: level/rise got %b want 11", {level, rise});
        end
        tick();
        nCompared++;
        if ({level, rise} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL reset_edge7: level/rise got %b want 10", {level, rise});
        end
    endtask

    task automatic test_clean();
        int riseCount, riseAt, fallCount, fallAt, both;
        riseCount = 0; riseAt = 0; fallCount = 0; fallAt = 0; both = 0;
        do_reset();
        raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (rise) begin riseCount++; riseAt = i; end
            if (fall) fallCount++;
            if (rise && fall) both++;
        end
        nCompared++;
        if (riseCount !== 1 || riseAt !== 6) begin
            nMismatched++;
            $display("[TB] FAIL clean_rise: count %0d at tick %0d, want 1 at 6", riseCount, riseAt);
        end
        nCompared++;
        if (level !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL clean_level_high: got %b want 1", level);
        end
        raw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fall) begin fallCount++; fallAt = i; end
            if (rise) riseCount++;
            if (rise && fall) both++;
        end
        nCompared++;
        if (fallCount !== 1 || fallAt !== 6 || riseCount !== 1) begin
            nMismatched++;
            $display("[TB] FAIL clean_fall: fall %0d at %0d rise %0d, want 1 at 6 rise 1", fallCount, fallAt, riseCount);
        end
        nCompared++;
        if (level !== 1'b0 || bc !== 8'd0 || both !== 0) begin
            nMismatched++;
            $display("[TB] FAIL clean_end: level %b bc %0d overlap %0d, want 0 0 0", level, bc, both);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        int riseCount;
        pattern = 5'b10101;
        riseCount = 0;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            raw = pattern[i];
            tick();
            if (rise) riseCount++;
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rise) riseCount++;
        end
        nCompared++;
        if (riseCount !== 1) begin
            nMismatched++;
            $display("[TB] FAIL bounce_rise_count: got %0d want 1", riseCount);
        end
        nCompared++;
        if (level !== 1'b1 || bc !== 8'd2) begin
            nMismatched++;
            $display("[TB] FAIL bounce_end: level %b bc %0d, want 1 2", level, bc);
        end
    endtask

    task automatic test_glitch();
        int busyCount, riseCount, levelHigh;
        busyCount = 0; riseCount = 0; levelHigh = 0;
        do_reset();
        raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) busyCount++;
            if (rise) riseCount++;
            if (level) levelHigh++;
        end
        raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busyCount++;
            if (rise) riseCount++;
            if (level) levelHigh++;
        end
        nCompared++;
        if (busyCount !== 3) begin
            nMismatched++;
            $display("[TB] FAIL glitch_busy: got %0d cycles want 3", busyCount);
        end
        nCompared++;
        if (riseCount !== 0 || levelHigh !== 0 || bc !== 8'd1) begin
            nMismatched++;
            $display("[TB] FAIL glitch_end: rise %0d levelHigh %0d bc %0d, want 0 0 1", riseCount, levelHigh, bc);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] expSat [5];
        expSat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int g = 0; g < 5; g++) begin
            raw = 1'b1;
            tick();
            raw = 1'b0;
            for (int i = 0; i < 5; i++) tick();
            nCompared++;
            if (bc2 !== expSat[g]) begin
                nMismatched++;
                $display("[TB] FAIL sat_bc2_%0d: got %0d want %0d", g, bc2, expSat[g]);
            end
        end
        nCompared++;
        if (bc !== 8'd5) begin
            nMismatched++;
            $display("[TB] FAIL sat_bc_wide: got %0d want 5", bc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw = 1'b1;
        tick();
        raw = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        nCompared++;
        if (bc !== 8'd1) begin
            nMismatched++;
            $display("[TB] FAIL mid_pre_bc: got %0d want 1", bc);
        end
        raw = 1'b1;
        tick(); tick(); tick();
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        nCompared++;
        if ({busy, level, rise, fall} !== 4'b0000 || bc !== 8'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset: flags %b bc %0d, want 0000 0", {busy, level, rise, fall}, bc);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        nCompared++;
        if ({busy, level, rise} !== 3'b100) begin
            nMismatched++;
            $display("[TB] FAIL mid_edge5: busy/level/rise got %b want 100", {busy, level, rise});
        end
        tick();
        nCompared++;
        if ({busy, level, rise, fall} !== 4'b0110) begin
            nMismatched++;
            $display("[TB] FAIL mid_edge6: busy/level/rise/fall got %b want 0110", {busy, level, rise, fall});
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        raw = 1'b0;
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_clean();
        test_bounce();
        test_glitch();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
